// File: rtl/router_pkg.sv
// Shared types and constants for the router output channel and its VC FIFOs.
package router_pkg;

    // Default flit width on the inter-router link.
    localparam int unsigned FLIT_W = 64;

    // Number of virtual channels per output port.
    localparam int unsigned NUM_VC = 2;

    // Virtual-channel identifier.
    typedef logic [0:0] vc_id_t;

    // VC1 carries even-polarity traffic, VC2 carries odd-polarity traffic.
    localparam vc_id_t VC1 = 1'b0;
    localparam vc_id_t VC2 = 1'b1;

    // A posedge seen with polarity high leads into an even cycle, so it serves VC1.
    function automatic vc_id_t sel_vc(input logic polarity);
        return vc_id_t'(~polarity);
    endfunction

endpackage

// File: rtl/router_output_channel_if.sv
// Crossbar-side push handshake and downstream link signals of one router output port.
// The master side is the crossbar plus downstream input channel; the slave side is
// router_output_channel.
interface router_output_channel_if #(
    parameter int unsigned DATA_W = router_pkg::FLIT_W
);
    import router_pkg::*;

    // Crossbar push port.
    logic              xbar_valid;
    vc_id_t            xbar_vc;
    logic [DATA_W-1:0] xbar_data;
    logic              xbar_ready;

    // Inter-router link.
    logic              ready_in;
    logic              send_out;
    logic [DATA_W-1:0] data_out;

    modport master (
        output xbar_valid,
        output xbar_vc,
        output xbar_data,
        output ready_in,
        input  xbar_ready,
        input  send_out,
        input  data_out
    );

    modport slave (
        input  xbar_valid,
        input  xbar_vc,
        input  xbar_data,
        input  ready_in,
        output xbar_ready,
        output send_out,
        output data_out
    );

endinterface

// File: rtl/router_vc_fifo.sv
// Single virtual-channel FIFO: circular buffer with an explicit occupancy count,
// synchronous active-high reset. Push into a full FIFO and pop from an empty one are
// ignored, so the pointers never overrun.
module router_vc_fifo #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned VC_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(VC_DEPTH + 1);

    logic [DATA_W-1:0] mem_q [VC_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(VC_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(VC_DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next-state pointers and occupancy; a simultaneous push and pop leaves the count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = bump(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = bump(rd_ptr_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/count state; reset flushes the FIFO by clearing the count and pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because occupancy comes from the count.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/router_output_channel.sv
// Output-port stage of a mesh router: two VC FIFOs fed by the crossbar, drained onto the
// inter-router link on the cycle whose polarity matches each VC, while downstream is ready.
// Optional build macro ROUTER_OC_STATS_EN adds a 32-bit sent-flit counter output.
module router_output_channel
    import router_pkg::*;
#(
    parameter int unsigned DATA_W   = FLIT_W,
    parameter int unsigned VC_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  polarity,
    router_output_channel_if.slave link,
    output logic [NUM_VC-1:0]     vc_full,
    output logic [NUM_VC-1:0]     vc_empty
`ifdef ROUTER_OC_STATS_EN
    ,
    output logic [31:0]           sent_count
`endif
);

    vc_id_t            sel;
    logic [NUM_VC-1:0] push;
    logic [NUM_VC-1:0] pop;
    logic [DATA_W-1:0] head [NUM_VC];
    logic              send_d, send_q;
    logic [DATA_W-1:0] data_d, data_q;

    assign sel = sel_vc(polarity);

    // Ready depends only on registered FIFO state, never on ready_in or a same-cycle pop.
    assign link.xbar_ready = !vc_full[link.xbar_vc];

    // Push decode into the targeted VC; pop only the polarity-selected VC.
    always_comb begin
        push = '0;
        pop  = '0;
        push[link.xbar_vc] = link.xbar_valid && link.xbar_ready;
        pop[sel]           = link.ready_in && !vc_empty[sel];
        send_d             = pop[sel];
        data_d             = send_d ? head[sel] : '0;
    end

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        router_vc_fifo #(
            .DATA_W   (DATA_W),
            .VC_DEPTH (VC_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push[g]),
            .push_data (link.xbar_data),
            .pop       (pop[g]),
            .head      (head[g]),
            .full      (vc_full[g]),
            .empty     (vc_empty[g])
        );
    end

    // Registered link outputs; data is forced to zero on idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            send_q <= 1'b0;
            data_q <= '0;
        end else begin
            send_q <= send_d;
            data_q <= data_d;
        end
    end

    assign link.send_out = send_q;
    assign link.data_out = data_q;

`ifdef ROUTER_OC_STATS_EN
    logic [31:0] sent_count_q;

    // Count edges that launch a flit; wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            sent_count_q <= '0;
        end else if (send_d) begin
            sent_count_q <= sent_count_q + 32'd1;
        end
    end

    assign sent_count = sent_count_q;
`endif

endmodule

// File: tb/tb_router_output_channel.sv
// Randomized scoreboard bench for router_output_channel. A queue-based reference model
// updates on each posedge and pushes expected link flits; a monitor on the negedge pops
// and compares, and also checks status flags against the model's queue sizes.
module tb_router_output_channel;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       polarity;
    logic [1:0] vc_full;
    logic [1:0] vc_empty;
`ifdef ROUTER_OC_STATS_EN
    logic [31:0] sent_count;
`endif

    router_output_channel_if #(.DATA_W(DW)) link ();

    router_output_channel #(
        .DATA_W   (DW),
        .VC_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .polarity   (polarity),
        .link       (link.slave),
        .vc_full    (vc_full),
        .vc_empty   (vc_empty)
`ifdef ROUTER_OC_STATS_EN
        ,
        .sent_count (sent_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference state.
    logic [DW-1:0] mq [2][$];
    logic [DW-1:0] exp_q [$];
    logic          exp_send = 1'b0;
    int unsigned   exp_count = 0;
    bit            started = 1'b0;
    bit            done = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: on each edge, pop the polarity-selected VC if downstream is ready,
    // then accept the crossbar flit if its VC had room before the edge.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                mq[0].delete();
                mq[1].delete();
                exp_q.delete();
                exp_send  = 1'b0;
                exp_count = 0;
                started   = 1'b1;
            end else begin
                int  s;
                int  v;
                bit  accept;
                s      = polarity ? 0 : 1;
                v      = int'(link.xbar_vc);
                accept = link.xbar_valid && (mq[v].size() < DEPTH);
                if (link.ready_in && mq[s].size() > 0) begin
                    exp_q.push_back(mq[s].pop_front());
                    exp_send  = 1'b1;
                    exp_count = exp_count + 1;
                end else begin
                    exp_send = 1'b0;
                end
                if (accept) begin
                    mq[v].push_back(link.xbar_data);
                end
            end
        end
    end

    // Monitor: compare link outputs and status flags away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (started && !done) begin
                chk("send_out", {63'd0, link.send_out}, {63'd0, exp_send});
                if (link.send_out || exp_send) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_send", 64'd1, 64'd0);
                    end else begin
                        chk("data_out", link.data_out, exp_q.pop_front());
                    end
                end else begin
                    chk("idle_data_zero", link.data_out, '0);
                end
                chk("vc_empty", {62'd0, vc_empty},
                    {62'd0, mq[1].size() == 0, mq[0].size() == 0});
                chk("vc_full", {62'd0, vc_full},
                    {62'd0, mq[1].size() == DEPTH, mq[0].size() == DEPTH});
                chk("xbar_ready", {63'd0, link.xbar_ready},
                    {63'd0, mq[int'(link.xbar_vc)].size() < DEPTH});
`ifdef ROUTER_OC_STATS_EN
                chk("sent_count", {32'd0, sent_count}, {32'd0, exp_count});
`endif
            end
        end
    end

    // One cycle of stimulus, applied just after the negedge checks.
    task automatic cyc(input bit rst, input bit v, input bit vc, input logic [DW-1:0] d,
                       input bit rdy);
        @(negedge clk);
        #1;
        reset           = rst;
        link.xbar_valid = v;
        link.xbar_vc    = vc;
        link.xbar_data  = d;
        link.ready_in   = rdy;
        polarity        = ~polarity;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, rdy);
    endtask

    initial begin
        reset           = 1'b1;
        polarity        = 1'b0;
        link.xbar_valid = 1'b0;
        link.xbar_vc    = 1'b0;
        link.xbar_data  = '0;
        link.ready_in   = 1'b0;

        // Reset held for several cycles.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        idle(2, 1'b1);

        // Single flit into VC1 with downstream ready.
        cyc(1'b0, 1'b1, 1'b0, 64'hA, 1'b1);
        idle(4, 1'b1);

        // Three pushes into VC2 while held; the third is refused.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 64'h100 + 64'(i), 1'b0);
        idle(6, 1'b1);

        // Load both VCs then release: alternating drain.
        cyc(1'b0, 1'b1, 1'b0, 64'd1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 64'd2, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 64'd3, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 64'd4, 1'b0);
        idle(6, 1'b1);

        // Full VC1 offered pushes while draining; zero-valued flits included.
        cyc(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 64'h55, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 64'h200 + 64'(i), 1'b1);
        idle(6, 1'b1);

        // Reset while both VCs hold flits.
        cyc(1'b0, 1'b1, 1'b0, 64'h31, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 64'h32, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        idle(3, 1'b1);

        // Randomized traffic with occasional mid-operation reset.
        for (int i = 0; i < 3000; i++) begin
            logic [DW-1:0] d;
            d = ($urandom_range(0, 9) == 0) ? '0 : {$urandom(), $urandom()};
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, 1'($urandom()), d,
                $urandom_range(0, 3) != 0);
        end

        // Drain and confirm nothing is left anywhere.
        idle(8, 1'b1);
        @(negedge clk);
        #2;
        done = 1'b1;
        chk("drain_vc1", 64'(mq[0].size()), 64'd0);
        chk("drain_vc2", 64'(mq[1].size()), 64'd0);
        chk("drain_scoreboard", 64'(exp_q.size()), 64'd0);
        chk("drain_flags", {62'd0, vc_empty}, 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
